max7219_ctrl: RTL
=================

Name: max7219_ctrl

Overview:
Frame sequencer sitting directly upstream of the MAX7219 serial interface block. It drives that block's start/en_load/data inputs and consumes its done pulse. It issues the power-up configuration sequence, then refreshes the digit registers from a latched 64-bit display image on request. Pending-request tracking and a done-timeout watchdog let the system layer fire requests without handshaking each frame.

Parameters:
G_DONE_TIMEOUT, 4096, max clk cycles to wait for i_done after o_start before flagging error (>=2)
G_INIT_INTENSITY, 4'h8, intensity nibble sent during init when i_use_cfg=0

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_init  in  1  one-cycle pulse: request init sequence
i_update  in  1  one-cycle pulse: request digit refresh
i_use_cfg  in  1  1: use i_intensity for init; 0: use G_INIT_INTENSITY
i_intensity  in  4  intensity value (reg 0x0A)
i_scan_limit  in  3  scan limit (reg 0x0B); also number of digits refreshed minus 1
i_decode  in  8  decode-mode value (reg 0x09)
i_digits  in  64  display image, digit k (1..8) = i_digits[8k-1:8k-8]
o_start  out  1  one-cycle start pulse to interface block
o_en_load  out  1  load enable to interface block, held 1 while busy
o_data  out  16  frame {4'h0, addr[3:0], value[7:0]}, stable from o_start until i_done
i_done  in  1  one-cycle frame-complete pulse from interface block
o_busy  out  1  high from first frame issue until sequence end
o_init_done  out  1  sticky, set after init sequence completes, cleared by reset or new i_init
o_error  out  1  sticky timeout flag, cleared only by reset or i_init

Behaviour:
- Reset: all outputs 0, state IDLE, pending flags cleared, frame index 0. Asserting rst_n mid-frame aborts immediately, with no further o_start.
- States: IDLE, ISSUE, WAIT_DONE, NEXT, ERR.
- Requests are sampled every cycle into sticky pend_init/pend_upd flags, including while busy. A request arriving while its flag is already set merges into it.
- IDLE: if pend_init, go to ISSUE with init sequence selected and clear pend_init. Else if pend_upd and o_init_done=1, go to ISSUE with update sequence selected and clear pend_upd. init has priority on simultaneous requests. pend_upd with o_init_done=0 is held, not dropped.
- Init sequence, 5 frames in order: 0x0F00 (test off), 0x0B0s (s=i_scan_limit), 0x09dd (i_decode), 0x0A0i (intensity), 0x0C01 (normal operation). Config inputs are latched in the IDLE->ISSUE cycle.
- Update sequence: frames 0x01xx..0x0(n)xx, where n = latched i_scan_limit+1 (1..8) and xx is the digit byte. i_digits is latched in the IDLE->ISSUE cycle, so later changes do not affect the running sequence.
- ISSUE: drive o_data and o_start=1 for exactly 1 cycle, then go to WAIT_DONE. The timeout counter resets to 0.
- WAIT_DONE: the counter increments each cycle.
  - i_done=1: go to NEXT.
  - Counter reaches G_DONE_TIMEOUT-1 without i_done: set o_error and go to ERR.
  - i_done arriving while in ISSUE or IDLE is ignored.
- NEXT: increment frame index. If it was the last frame, go to IDLE, clear o_busy, and set o_init_done if this was the init sequence. Otherwise go to ISSUE.
- Latency:
  - Request pulse at edge N gives o_start high in cycle N+2 (flag at N+1, ISSUE at N+2).
  - i_done at edge M gives the next o_start at M+2.
  - After the last i_done, o_busy falls at M+2.
- ERR: o_busy=0, no frames issued, pend_upd ignored. Only i_init exits, restarting the init sequence and clearing o_error and o_init_done.
- i_init during a running update: the current frame completes, the update sequence is abandoned at the NEXT state, and init starts via IDLE.
- o_en_load = o_busy.

Test Plan:
- Reset, then i_init with i_use_cfg=0, i_scan_limit=7, i_decode=8'hFF, responder returning i_done 20 cycles after each o_start -> frames 0x0F00, 0x0B07, 0x09FF, 0x0A08, 0x0C01 in order; exactly 5 o_start pulses; o_init_done=1 two cycles after the 5th i_done.
- After init, i_update with i_scan_limit=3 and i_digits=64'h...44_33_22_11 -> frames 0x0111, 0x0222, 0x0333, 0x0444; o_busy falls 2 cycles after the last i_done.
- i_update before any init -> no o_start. A later i_init -> 5 init frames followed immediately by the pending update frames.
- i_init and i_update in the same cycle, and a second i_update pulsed mid-sequence -> init first, then exactly one merged update sequence.
- Responder withholds i_done, G_DONE_TIMEOUT=16 -> o_error=1 exactly 16 cycles after o_start; subsequent i_update is ignored; i_init clears o_error and restarts.
- rst_n deasserted during WAIT_DONE of update frame 2 -> all outputs 0 asynchronously; no o_start after release until a new request.

Source files
------------

// File: rtl/max7219_ctrl.sv
// Frame sequencer feeding the MAX7219 serial interface block: power-up configuration
// sequence, digit refresh from a latched display image, pending-request merging and a done watchdog.
module max7219_ctrl #(
  parameter int          G_DONE_TIMEOUT   = 4096,
  parameter logic [3:0]  G_INIT_INTENSITY = 4'h8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init,
  input  logic        i_update,
  input  logic        i_use_cfg,
  input  logic [3:0]  i_intensity,
  input  logic [2:0]  i_scan_limit,
  input  logic [7:0]  i_decode,
  input  logic [63:0] i_digits,
  output logic        o_start,
  output logic        o_en_load,
  output logic [15:0] o_data,
  input  logic        i_done,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_error
);

  localparam int CW = $clog2(G_DONE_TIMEOUT + 1);
  // The error edge lands G_DONE_TIMEOUT cycles after o_start rises, so compare one step early.
  localparam logic [CW-1:0] C_LAST = CW'(G_DONE_TIMEOUT - 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    NEXT      = 3'd3,
    ERR       = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          pend_init_q, pend_init_d;
  logic          pend_upd_q, pend_upd_d;
  logic          sel_init_q, sel_init_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    inten_q, inten_d;
  logic [2:0]    scan_q, scan_d;
  logic [7:0]    decode_q, decode_d;
  logic [63:0]   digits_q, digits_d;
  logic          start_q, start_d;
  logic [15:0]   data_q, data_d;
  logic          busy_q, busy_d;
  logic          init_done_q, init_done_d;
  logic          error_q, error_d;
  logic          launch_s, launch_init_s;
  logic [3:0]    eff_inten_s;
  logic [2:0]    last_idx_s;

  function automatic logic [15:0] frame_f(
    input logic        is_init,
    input logic [2:0]  idx,
    input logic [3:0]  inten,
    input logic [2:0]  scan,
    input logic [7:0]  dec,
    input logic [63:0] digs
  );
    logic [15:0] f;
    f = 16'h0000;
    if (is_init) begin
      case (idx)
        3'd0:    f = 16'h0F00;
        3'd1:    f = {8'h0B, 5'b00000, scan};
        3'd2:    f = {8'h09, dec};
        3'd3:    f = {8'h0A, 4'h0, inten};
        3'd4:    f = 16'h0C01;
        default: f = 16'h0F00;
      endcase
    end else begin
      f = {4'h0, {1'b0, idx} + 4'd1, digs[{idx, 3'b000} +: 8]};
    end
    return f;
  endfunction

  assign eff_inten_s = i_use_cfg ? i_intensity : G_INIT_INTENSITY;
  assign last_idx_s  = sel_init_q ? 3'd4 : scan_q;

  // Next-state, request tracking and registered-output computation.
  always_comb begin
    state_d       = state_q;
    pend_init_d   = pend_init_q | i_init;
    pend_upd_d    = pend_upd_q | i_update;
    sel_init_d    = sel_init_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    inten_d       = inten_q;
    scan_d        = scan_q;
    decode_d      = decode_q;
    digits_d      = digits_q;
    start_d       = 1'b0;
    data_d        = data_q;
    busy_d        = busy_q;
    error_d       = error_q;
    launch_s      = 1'b0;
    launch_init_s = 1'b0;
    if (i_init) begin
      init_done_d = 1'b0;
    end else begin
      init_done_d = init_done_q;
    end

    case (state_q)
      IDLE: begin
        if (pend_init_q) begin
          launch_s      = 1'b1;
          launch_init_s = 1'b1;
        end else if (pend_upd_q && init_done_q) begin
          launch_s      = 1'b1;
        end else begin
          state_d       = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        if (i_done) begin
          state_d = NEXT;
        end else if (cnt_q == C_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ERR;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      NEXT: begin
        if (idx_q == last_idx_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (sel_init_q) begin
            init_done_d = ~i_init;
          end else begin
            init_done_d = init_done_q & ~i_init;
          end
        end else if (!sel_init_q && pend_init_q) begin
          // Abandon the refresh so the pending init starts from IDLE.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ISSUE;
          start_d = 1'b1;
          data_d  = frame_f(sel_init_q, idx_q + 3'd1, inten_q, scan_q, decode_q, digits_q);
        end
      end
      ERR: begin
        pend_upd_d = 1'b0;
        if (pend_init_q) begin
          launch_s      = 1'b1;
          launch_init_s = 1'b1;
        end else begin
          state_d       = ERR;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (launch_s) begin
      state_d    = ISSUE;
      start_d    = 1'b1;
      busy_d     = 1'b1;
      idx_d      = 3'd0;
      sel_init_d = launch_init_s;
      inten_d    = eff_inten_s;
      scan_d     = i_scan_limit;
      decode_d   = i_decode;
      digits_d   = i_digits;
      data_d     = frame_f(launch_init_s, 3'd0, eff_inten_s, i_scan_limit, i_decode, i_digits);
      if (launch_init_s) begin
        pend_init_d = 1'b0;
        error_d     = 1'b0;
        init_done_d = 1'b0;
      end else begin
        pend_upd_d  = 1'b0;
      end
    end else begin
      sel_init_d = sel_init_q;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_init_q <= 1'b0;
      pend_upd_q  <= 1'b0;
      sel_init_q  <= 1'b0;
      idx_q       <= 3'd0;
      cnt_q       <= '0;
      inten_q     <= 4'h0;
      scan_q      <= 3'd0;
      decode_q    <= 8'h00;
      digits_q    <= 64'h0;
      start_q     <= 1'b0;
      data_q      <= 16'h0000;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_init_q <= pend_init_d;
      pend_upd_q  <= pend_upd_d;
      sel_init_q  <= sel_init_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      inten_q     <= inten_d;
      scan_q      <= scan_d;
      decode_q    <= decode_d;
      digits_q    <= digits_d;
      start_q     <= start_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
    end
  end

  assign o_start     = start_q;
  assign o_en_load   = busy_q;
  assign o_data      = data_q;
  assign o_busy      = busy_q;
  assign o_init_done = init_done_q;
  assign o_error     = error_q;

endmodule
